audio_clk_gen: RTL and testbench



---
 rtl/audio_clk_gen.sv | 123 ++++++++++++
 tb/tb_audio_clk_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_clk_gen.sv
// Multi-channel clock/strobe generator. Each channel is an integer half-period divider or an NCO,
// with a shadow config that is applied only at the end of a full output period.
module audio_clk_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CH_W        = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned DEFAULT_DIV = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic              cfg_mode_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    input  logic [ACC_W-1:0]  cfg_inc_i,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] stb_o
);

    typedef struct packed {
        logic             mode;
        logic [CNT_W-1:0] div;
        logic [ACC_W-1:0] inc;
    } cfg_t;

    cfg_t              act_q [NUM_CH];
    cfg_t              act_d [NUM_CH];
    cfg_t              sh_q  [NUM_CH];
    cfg_t              sh_d  [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] stb_q, stb_d;
    logic [NUM_CH-1:0] held, apply;
    logic              cfg_acc;

    // Ready follows the addressed channel's pending flag; out-of-range channels always accept.
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (cfg_ch_i == CH_W'(c)) cfg_ready_o = ~pend_q[c];
        end
    end

    assign cfg_acc = cfg_valid_i & cfg_ready_o;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            act_d[c]  = act_q[c];
            sh_d[c]   = sh_q[c];
            pend_d[c] = pend_q[c];
            cnt_d[c]  = '0;
            acc_d[c]  = '0;
            clk_d[c]  = 1'b0;
            held[c]   = act_q[c].mode ? (act_q[c].inc == '0) : (act_q[c].div == '0);

            if (en_i[c]) begin
                if (act_q[c].mode) begin
                    acc_d[c] = acc_q[c] + act_q[c].inc;
                    clk_d[c] = acc_d[c][ACC_W-1];
                end else if (!held[c]) begin
                    if (cnt_q[c] == act_q[c].div - CNT_W'(1)) begin
                        clk_d[c] = ~clk_q[c];
                    end else begin
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        clk_d[c] = clk_q[c];
                    end
                end
            end

            // Swap in the shadow only on a falling output edge, when idle-low, or when disabled.
            apply[c] = pend_q[c] & (~en_i[c] | (clk_q[c] & ~clk_d[c]) | (held[c] & ~clk_q[c]));
            if (apply[c]) begin
                act_d[c]  = sh_q[c];
                pend_d[c] = 1'b0;
                cnt_d[c]  = '0;
                acc_d[c]  = '0;
                clk_d[c]  = 1'b0;
            end

            stb_d[c] = clk_d[c] & ~clk_q[c];

            if (cfg_acc && (cfg_ch_i == CH_W'(c))) begin
                sh_d[c]   = '{mode: cfg_mode_i, div: cfg_div_i, inc: cfg_inc_i};
                pend_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                act_q[c] <= '{mode: 1'b0, div: CNT_W'(DEFAULT_DIV), inc: '0};
                sh_q[c]  <= '{mode: 1'b0, div: CNT_W'(DEFAULT_DIV), inc: '0};
                cnt_q[c] <= '0;
                acc_q[c] <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            stb_q  <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                act_q[c] <= act_d[c];
                sh_q[c]  <= sh_d[c];
                cnt_q[c] <= cnt_d[c];
                acc_q[c] <= acc_d[c];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            stb_q  <= stb_d;
        end
    end

    assign clk_o = clk_q;
    assign stb_o = stb_q;

endmodule

// File: tb/tb_audio_clk_gen.sv
// Bench for audio_clk_gen: directed scenarios plus random traffic, every cycle checked against
// a period-arithmetic reference model (level = f(cycles since restart)).
module tb_audio_clk_gen;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned CH_W        = 2;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned ACC_W       = 24;
    localparam int unsigned DEFAULT_DIV = 1000;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NUM_CH-1:0] en_i;
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [CH_W-1:0]   cfg_ch_i;
    logic              cfg_mode_i;
    logic [CNT_W-1:0]  cfg_div_i;
    logic [ACC_W-1:0]  cfg_inc_i;
    logic [NUM_CH-1:0] clk_o;
    logic [NUM_CH-1:0] stb_o;

    always #5 clk = ~clk;

    audio_clk_gen #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .ACC_W(ACC_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_ch_i(cfg_ch_i),
        .cfg_mode_i(cfg_mode_i), .cfg_div_i(cfg_div_i), .cfg_inc_i(cfg_inc_i),
        .clk_o(clk_o), .stb_o(stb_o)
    );

    // Reference model: active/shadow config and elapsed counting cycles k per channel.
    bit              m_mode [NUM_CH];
    longint unsigned m_div  [NUM_CH];
    longint unsigned m_inc  [NUM_CH];
    bit              s_mode [NUM_CH];
    longint unsigned s_div  [NUM_CH];
    longint unsigned s_inc  [NUM_CH];
    bit              m_pend [NUM_CH];
    longint unsigned m_k    [NUM_CH];
    bit              m_clk  [NUM_CH];
    bit              m_stb  [NUM_CH];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_div[c] = DEFAULT_DIV; m_inc[c] = 0;
            s_mode[c] = 0; s_div[c] = DEFAULT_DIV; s_inc[c] = 0;
            m_pend[c] = 0; m_k[c] = 0; m_clk[c] = 0; m_stb[c] = 0;
        end
    endfunction

    function automatic bit model_ready();
        bit r = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            if (int'(cfg_ch_i) == c) r = !m_pend[c];
        return r;
    endfunction

    function automatic void model_apply(input int c);
        m_mode[c] = s_mode[c]; m_div[c] = s_div[c]; m_inc[c] = s_inc[c];
        m_pend[c] = 0; m_k[c] = 0; m_clk[c] = 0; m_stb[c] = 0;
    endfunction

    function automatic void model_step();
        bit              take;
        bit              nclk;
        bit              idle;
        longint unsigned nk;
        if (rst_i) begin
            model_reset();
            return;
        end
        take = cfg_valid_i && model_ready();
        for (int c = 0; c < NUM_CH; c++) begin
            if (!en_i[c]) begin
                if (m_pend[c]) model_apply(c);
                m_k[c] = 0; m_clk[c] = 0; m_stb[c] = 0;
            end else begin
                nk = m_k[c] + 1;
                if (!m_mode[c]) nclk = (m_div[c] == 0) ? 1'b0 : bit'((nk / m_div[c]) % 2);
                else            nclk = bit'(((nk * m_inc[c]) >> (ACC_W - 1)) & 1);
                idle = m_mode[c] ? (m_inc[c] == 0) : (m_div[c] == 0);
                if (m_pend[c] && ((m_clk[c] && !nclk) || (idle && !m_clk[c]))) begin
                    model_apply(c);
                end else begin
                    m_stb[c] = nclk && !m_clk[c];
                    m_clk[c] = nclk;
                    m_k[c]   = nk;
                end
            end
        end
        if (take && int'(cfg_ch_i) < NUM_CH) begin
            s_mode[cfg_ch_i] = cfg_mode_i;
            s_div[cfg_ch_i]  = cfg_div_i;
            s_inc[cfg_ch_i]  = cfg_inc_i;
            m_pend[cfg_ch_i] = 1;
        end
    endfunction

    task automatic step();
        logic [NUM_CH-1:0] ec, es;
        @(negedge clk);
        chk("ready", cfg_ready_o, model_ready());
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            ec[c] = m_clk[c];
            es[c] = m_stb[c];
        end
        chk("clk_o", clk_o, ec);
        chk("stb_o", stb_o, es);
        cyc++;
    endtask

    task automatic run_until(input int ch, input logic lvl, input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (clk_o[ch] !== lvl && n < maxc);
        chk("run_until", clk_o[ch], lvl);
    endtask

    task automatic send(input int ch, input bit mode, input int div, input int inc);
        cfg_valid_i = 1'b1;
        cfg_ch_i    = CH_W'(ch);
        cfg_mode_i  = mode;
        cfg_div_i   = CNT_W'(div);
        cfg_inc_i   = ACC_W'(inc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rise, second_rise, nstb, nhigh, n, hi, lo, s0, s1, ms1;
        logic [31:0] stbv, clkv;

        model_reset();
        rst_i = 1'b1; en_i = '0; cfg_valid_i = 1'b0; cfg_ch_i = '0;
        cfg_mode_i = 1'b0; cfg_div_i = '0; cfg_inc_i = '0;
        repeat (3) step();
        chk("rst_clk", clk_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_ready", cfg_ready_o, 1);
        rst_i = 1'b0;

        // Default divider on ch0.
        en_i = 3'b001;
        first_rise = -1; second_rise = -1; nstb = 0;
        for (int i = 1; i <= 4200; i++) begin
            step();
            if (stb_o[0] === 1'b1) begin
                nstb++;
                if (first_rise < 0) first_rise = i;
                else if (second_rise < 0) second_rise = i;
            end
        end
        chk("t1_first_rise", first_rise, DEFAULT_DIV);
        chk("t1_period", second_rise - first_rise, 2 * DEFAULT_DIV);
        chk("t1_nstb", nstb, 2);

        // div = 4 from idle.
        en_i = 3'b000; send(0, 0, 4, 0); step();
        cfg_valid_i = 1'b0; step();
        en_i[0] = 1'b1; stbv = '0; clkv = '0;
        for (int i = 1; i <= 24; i++) begin
            step();
            stbv[i] = stb_o[0];
            clkv[i] = clk_o[0];
        end
        chk("t2_stb", stbv, 32'h0010_1010);
        chk("t2_clk", clkv, 32'h00F0_F0F0);

        // Fractional ch1, inc = 2^(ACC_W-3): period 8.
        send(1, 1, 0, 1 << (ACC_W - 3)); step();
        cfg_valid_i = 1'b0; step();
        en_i[1] = 1'b1; nstb = 0; nhigh = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            nstb  += int'(stb_o[1]);
            nhigh += int'(clk_o[1]);
        end
        chk("t3_nstb8", nstb, 4);
        chk("t3_high8", nhigh, 16);
        en_i[1] = 1'b0; send(1, 1, 0, 3 << (ACC_W - 5)); step();
        cfg_valid_i = 1'b0; step();
        en_i[1] = 1'b1; nstb = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            nstb += int'(stb_o[1]);
        end
        chk("t3_nstb_frac", nstb, 3);

        // Reconfigure ch0 mid-high-phase; a second request is held until ready returns.
        n = 0;
        while (stb_o[0] !== 1'b1 && n < 20) begin step(); n++; end
        chk("t4_sync", stb_o[0], 1);
        send(0, 0, 2, 0); step();
        cfg_div_i = CNT_W'(4);
        run_until(0, 1'b0, 20, hi);
        chk("t4_old_high", hi + 1, 4);
        run_until(0, 1'b1, 20, lo);
        chk("t4_new_low", lo, 2);
        run_until(0, 1'b0, 20, hi);
        chk("t4_new_high", hi, 2);
        cfg_valid_i = 1'b0;

        // Disable while high with a config pending.
        run_until(0, 1'b1, 20, n);
        send(0, 0, 3, 0); step();
        cfg_valid_i = 1'b0; en_i[0] = 1'b0; step();
        chk("t5_clk_low", clk_o[0], 0);
        chk("t5_ready", cfg_ready_o, 1);
        en_i[0] = 1'b1;
        run_until(0, 1'b1, 20, n);
        chk("t5_first_rise", n, 3);

        // div = 0 holds ch0 low; ch1 keeps running; out-of-range channel is swallowed.
        en_i[0] = 1'b0; send(0, 0, 0, 0); step();
        cfg_valid_i = 1'b0; step();
        en_i[0] = 1'b1; s0 = 0; s1 = 0; ms1 = 0; nhigh = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            s0    += int'(stb_o[0]);
            nhigh += int'(clk_o[0]);
            s1    += int'(stb_o[1]);
            ms1   += int'(m_stb[1]);
        end
        chk("t6_stb0", s0, 0);
        chk("t6_clk0", nhigh, 0);
        chk("t6_stb1", s1, ms1);
        send(3, 0, 7, 0);
        #1;
        chk("t6_oor_ready", cfg_ready_o, 1);
        step();
        cfg_valid_i = 1'b0;
        repeat (4) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_i = (i == 1500);
            if ($urandom_range(63) == 0) en_i[$urandom_range(NUM_CH - 1)] ^= 1'b1;
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: send($urandom_range(3), 1, 0, 0);
                    1: send($urandom_range(3), 1, 0, int'($urandom_range(1 << 20)));
                    2: send($urandom_range(3), 1, 0, int'($urandom & 32'h00FF_FFFF));
                    default: send($urandom_range(3), 0, $urandom_range(9), 0);
                endcase
            end else begin
                cfg_valid_i = 1'b0;
            end
            step();
        end
        rst_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
